mmio_fact_unit: RTL
===================

Name: mmio_fact_unit

Overview:
- Memory-mapped iterative factorial accelerator on the data-memory bus of mips_top. It consumes the core's store/load traffic (we_dm, alu_out, wd_dm) and decodes its own 16-byte register window.
- It gates data-memory writes away from that window.
- It returns either its own register value or the data-memory read data to the core.
- Software writes N, writes GO, polls STATUS, then reads RESULT.

Parameters:
- BASE_ADDR, 32'h0000_0800, byte base address of the 16-byte register window; bits [3:0] must be zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  core store enable (we_dm).
- a  input  32  core byte address (alu_out).
- wd  input  32  core store data (wd_dm).
- rd_dm  input  32  read data from data memory.
- we_mem  output  1  write enable forwarded to data memory.
- rd  output  32  read data returned to core.
- hit  output  1  access targets the register window.

Behaviour:
- Decode: hit = (a[31:4] == BASE_ADDR[31:4]). Register select is a[3:2]; a[1:0] is ignored.
  - 0 = N (RW)
  - 1 = GO (WO, reads 0)
  - 2 = STATUS (RO, {30'b0, err, done})
  - 3 = RESULT (RO)
- we_mem = we & ~hit, combinational. Memory never sees window stores.
- rd = hit ? selected register (N zero-extended from 4 bits) : rd_dm, combinational, zero latency.
- Registers:
  - n_reg[3:0], cnt[3:0], acc[31:0], done, err.
  - State is IDLE, BUSY or DONE.
- Reset (synchronous, overrides everything, including mid-BUSY):
  - state=IDLE, n_reg=0, cnt=0, acc=0, done=0, err=0.
  - Outputs after reset: STATUS reads 0, RESULT reads 0. we_mem, rd and hit remain purely combinational.
- N write (we & hit & sel==0): n_reg <= wd[3:0] in IDLE or DONE; ignored in BUSY.
- GO write (we & hit & sel==1 & wd[0]==1):
  - Accepted in IDLE or DONE; ignored in BUSY. A GO write with wd[0]=0 has no effect.
  - On acceptance, if n_reg <= 12: cnt<=n_reg, acc<=1, done<=0, err<=0, next state BUSY.
  - On acceptance, if n_reg >= 13 (overflow of 32 bits): acc<=0, err<=1, done<=1, next state DONE immediately.
- Writes to STATUS or RESULT are ignored.
- BUSY, each edge:
  - If cnt <= 1: done<=1, state<=DONE, acc unchanged.
  - Else: acc <= acc * cnt (low 32 bits; never overflows for n<=12), cnt <= cnt-1.
- Latency: done is set on the max(n,1)-th rising edge after the GO-accept edge.
  - n=0 and n=1 give 1 edge with RESULT=1.
  - n=5 gives 5 edges with RESULT=120.
- DONE: RESULT and STATUS hold until the next accepted GO or reset. A new N write does not alter RESULT.
- While BUSY, RESULT reads the intermediate acc and STATUS reads 0.
- Only one bus access occurs per cycle. A write to N in the same cycle the FSM finishes is governed by state at that edge (BUSY means ignored).

Test Plan:
1. Reset, then store 5 to BASE+0 and 1 to BASE+4. STATUS reads 0 for 4 cycles and 0x1 on the 5th edge; RESULT=120. we_mem is 0 during both stores.
2. N=0, GO, then N=1, GO. Each gives done after 1 edge, RESULT=1, err=0. N=12 gives RESULT=479001600 (0x1C8CFC00) after 12 edges.
3. N=13, GO. On the accept edge STATUS=0x3 and RESULT=0. A following N=3 plus GO clears err and gives RESULT=6.
4. Start N=10. Mid-BUSY, write N=2 and GO, then check: n_reg still reads 10, RESULT=3628800 after 10 edges, no restart.
5. Start N=8. Assert rst for one cycle at edge 4: state IDLE, STATUS=0, RESULT=0, N reads 0. A following GO with N=0 gives RESULT=1.
6. Store and load at address 0x10 and at BASE+16. hit=0, we_mem=we, rd=rd_dm. Storing wd=0 to GO does not start the FSM. A load from BASE+4 returns 0.

Source files
------------

// File: rtl/mmio_fact_unit.sv
// mmio_fact_unit
//   Memory-mapped iterative factorial accelerator on the data-memory bus.
//   It decodes a 16-byte register window at BASE_ADDR and keeps window
//   stores away from data memory. Loads that hit the window return a unit
//   register, and all other loads return data-memory read data.
//
//   Register map (select = a[3:2], a[1:0] ignored):
//     0 N      RW  4-bit operand, zero-extended on read
//     1 GO     WO  store with wd[0]=1 starts a computation, reads 0
//     2 STATUS RO  {30'b0, err, done}
//     3 RESULT RO  accumulator (intermediate value while busy)
//
//   Ports:
//     clk     system clock, rising edge
//     rst     synchronous active-high reset
//     we      core store enable
//     a       core byte address
//     wd      core store data
//     rd_dm   data-memory read data
//     we_mem  store enable forwarded to data memory
//     rd      read data returned to the core
//     hit     access targets the register window
module mmio_fact_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [31:0] rd_dm,
  output logic        we_mem,
  output logic [31:0] rd,
  output logic        hit
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  n_reg, n_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] acc, acc_d;
  logic        done, done_d;
  logic        err, err_d;

  logic [1:0]  sel;
  logic        wr_n, wr_go;

  // Byte lanes and the upper store-data bits carry no meaning for this unit.
  logic        unused_bits;
  assign unused_bits = ^{a[1:0], wd[31:4], BASE_ADDR[3:0]};

  assign hit    = (a[31:4] == BASE_ADDR[31:4]);
  assign sel    = a[3:2];
  assign we_mem = we & ~hit;
  assign wr_n   = we & hit & (sel == 2'd0);
  assign wr_go  = we & hit & (sel == 2'd1) & wd[0];

  always_comb begin
    rd = rd_dm;
    if (hit) begin
      case (sel)
        2'd0:    rd = {28'd0, n_reg};
        2'd1:    rd = 32'd0;
        2'd2:    rd = {30'd0, err, done};
        default: rd = acc;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_reg;
    cnt_d   = cnt;
    acc_d   = acc;
    done_d  = done;
    err_d   = err;
    case (state_q)
      BUSY: begin
        // N and GO stores are dropped while a computation is running.
        if (cnt <= 4'd1) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          acc_d = acc * {28'd0, cnt};
          cnt_d = cnt - 4'd1;
        end
      end
      default: begin
        if (wr_n) begin
          n_d = wd[3:0];
        end
        if (wr_go) begin
          // 13! no longer fits in 32 bits, so report it immediately.
          if (n_reg <= 4'd12) begin
            cnt_d   = n_reg;
            acc_d   = 32'd1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = BUSY;
          end else begin
            acc_d   = 32'd0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_reg   <= 4'd0;
      cnt     <= 4'd0;
      acc     <= 32'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      n_reg   <= n_d;
      cnt     <= cnt_d;
      acc     <= acc_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule
